seg_scanner: RTL and testbench

SEG_SCANNER -- requirements
Module: seg_scanner

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_scanner_hex7seg.sv | 19 +
 rtl/seg_scanner.sv | 164 ++++++++++++++++
 tb/tb_seg_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants and helpers for the seven-segment scanner.
//                Holds the register addresses, the idle value of the display
//                drive and the hex-to-segment lookup table.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam logic [31:0] DISP_VAL_ADDR  = 32'h4000_0014;
    localparam logic [31:0] DISP_CTRL_ADDR = 32'h4000_0018;

    // All anodes off (active-low), all segments off.
    localparam logic [11:0] LEDS_RESET = 12'hF00;

    // Segment patterns {g,f,e,d,c,b,a}; element [n] encodes hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Mask of digits that carry significance: every digit up to and
    // including the highest nonzero nibble. Digit 0 is always visible so a
    // zero value still shows a single "0".
    function automatic logic [3:0] visible_digits(input logic [15:0] value);
        logic [3:0] mask;
        mask = 4'b0001;
        if (value[15:12] != 4'h0) begin
            mask = 4'b1111;
        end else if (value[11:8] != 4'h0) begin
            mask = 4'b0111;
        end else if (value[7:4] != 4'h0) begin
            mask = 4'b0011;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scanner_hex7seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg
//  Description : Combinational hex nibble to seven-segment encoder.
//  Ports       : nibble_i [3:0] - hex digit in
//                seg_o    [6:0] - active-high segments {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scanner
//  Description : Memory-mapped 4-digit multiplexed seven-segment driver.
//                DISP_VAL (0x4000_0014) holds four hex nibbles, DISP_CTRL
//                (0x4000_0018) holds enable (bit0) and the decimal-point mask
//                (bits [7:4]). A divider paces one digit slot per REFRESH_DIV
//                clocks; a shadow copy of DISP_VAL is taken at each frame
//                boundary so a frame never shows a torn value.
//  Ports       : clk, reset (async, active-high)
//                MemRead, MemWrite, Address[31:0], Write_data[31:0] - CPU bus
//                Read_data[31:0] - combinational register readback
//                leds[11:0]      - {anodes[3:0] active-low, dp,g..a}
//  Options     : SEG_LEADING_ZERO_BLANK_EN - blank digits above the highest
//                nonzero nibble (decimal points still follow the mask).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [11:0] leds
);

    localparam int unsigned             DIV_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]        C_DIV_TERM = DIV_W'(REFRESH_DIV - 1);

    // Architectural registers
    logic [15:0]      val_q,      val_d;
    logic             en_q,       en_d;
    logic [3:0]       dp_mask_q,  dp_mask_d;
    // Scan state
    logic [15:0]      shadow_q,   shadow_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic [1:0]       idx_q,      idx_d;
    // Digit latched at tick, presented on leds the following cycle
    logic             pend_q,     pend_d;
    logic [1:0]       pend_idx_q, pend_idx_d;
    logic [6:0]       pend_seg_q, pend_seg_d;
    logic [11:0]      leds_q,     leds_d;

    logic             w_wr_val;
    logic             w_wr_ctrl;
    logic             w_tick;
    logic [3:0]       w_nibble;
    logic [6:0]       w_hex_seg;
    logic [6:0]       w_seg_shown;
    logic             unused_wdata;

    assign w_wr_val  = MemWrite && (Address == DISP_VAL_ADDR);
    assign w_wr_ctrl = MemWrite && (Address == DISP_CTRL_ADDR);
    assign w_tick    = en_q && (div_q == C_DIV_TERM);
    assign w_nibble  = shadow_q[{idx_q, 2'b00} +: 4];

    assign unused_wdata = ^{Write_data[31:16], Write_data[3:1]};

    hex7seg u_hex7seg (
        .nibble_i (w_nibble),
        .seg_o    (w_hex_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [3:0] w_visible;
    assign w_visible   = visible_digits(shadow_q);
    assign w_seg_shown = w_visible[idx_q] ? w_hex_seg : 7'h00;
`else
    assign w_seg_shown = w_hex_seg;
`endif

    always_comb begin
        val_d      = w_wr_val  ? Write_data[15:0] : val_q;
        en_d       = w_wr_ctrl ? Write_data[0]    : en_q;
        dp_mask_d  = w_wr_ctrl ? Write_data[7:4]  : dp_mask_q;
        shadow_d   = shadow_q;
        div_d      = div_q;
        idx_d      = idx_q;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        pend_seg_d = pend_seg_q;
        leds_d     = leds_q;

        if (en_q) begin
            if (w_tick) begin
                div_d      = '0;
                idx_d      = idx_q + 2'd1;
                pend_d     = 1'b1;
                pend_idx_d = idx_q;
                pend_seg_d = w_seg_shown;
                // Frame boundary: forward a same-cycle DISP_VAL write.
                if (idx_q == 2'd3) begin
                    shadow_d = val_d;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            if (pend_q) begin
                leds_d = {~(4'b0001 << pend_idx_q), dp_mask_q[pend_idx_q], pend_seg_q};
            end
        end

        // Control writes override the scan: disable blanks, enable restarts.
        if (w_wr_ctrl && !Write_data[0]) begin
            div_d  = '0;
            idx_d  = 2'd0;
            pend_d = 1'b0;
            leds_d = LEDS_RESET;
        end else if (w_wr_ctrl && Write_data[0] && !en_q) begin
            shadow_d = val_q;
            div_d    = '0;
            idx_d    = 2'd0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q      <= 16'h0000;
            en_q       <= 1'b0;
            dp_mask_q  <= 4'h0;
            shadow_q   <= 16'h0000;
            div_q      <= '0;
            idx_q      <= 2'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            pend_seg_q <= 7'h00;
            leds_q     <= LEDS_RESET;
        end else begin
            val_q      <= val_d;
            en_q       <= en_d;
            dp_mask_q  <= dp_mask_d;
            shadow_q   <= shadow_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            pend_seg_q <= pend_seg_d;
            leds_q     <= leds_d;
        end
    end

    always_comb begin
        Read_data = 32'h0;
        if (MemRead) begin
            if (Address == DISP_VAL_ADDR) begin
                Read_data = {16'h0, val_q};
            end else if (Address == DISP_CTRL_ADDR) begin
                Read_data = {24'h0, dp_mask_q, 3'b000, en_q};
            end
        end
    end

    assign leds = leds_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scanner
//  Description : Scoreboard bench for seg_scanner with REFRESH_DIV = 4.
//                A cycle-indexed reference model predicts every change on
//                leds (value and clock cycle); a monitor compares each change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scanner;

    localparam logic [31:0] VAL_A  = 32'h4000_0014;
    localparam logic [31:0] CTRL_A = 32'h4000_0018;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] Write_data = 32'h0;
    logic [31:0] Read_data;
    logic [11:0] leds;

    always #5 clk = ~clk;

    seg_scanner #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .leds       (leds)
    );

    typedef struct {
        int          t;   // expected posedge count, -1 = asynchronous
        logic [11:0] v;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    logic [15:0] m_val  = 16'h0;
    logic        m_en   = 1'b0;
    logic [3:0]  m_dpm  = 4'h0;
    logic [11:0] m_leds = 12'hF00;
    int          c0     = 0;
    logic [15:0] snap [int];

    // Highest significant digit of a frame value (0 for value 0).
    function automatic int top_digit(input logic [15:0] v);
        int h;
        h = 0;
        for (int i = 0; i < 4; i++) begin
            if (((v >> (4 * i)) & 16'hF) != 0) h = i;
        end
        return h;
    endfunction

    // Model: after enabling at cycle c0, digit k of frame f appears at
    // cycle c0 + 16f + 4k + 5, using the value latched at cycle c0 + 16f.
    initial begin
        int          t, f, k;
        logic [15:0] fv;
        logic [3:0]  nib, an;
        logic [6:0]  seg;
        logic [11:0] cand;
        exp_t        e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                cand = m_leds;
                if (m_en) begin
                    t = cyc - c0;
                    if (t >= 5 && ((t - 5) % 4) == 0) begin
                        f   = (t - 5) / 16;
                        k   = ((t - 5) / 4) % 4;
                        fv  = snap[f];
                        nib = fv[4 * k +: 4];
                        seg = HEX[nib];
`ifdef SEG_LEADING_ZERO_BLANK_EN
                        if (k > top_digit(fv)) seg = 7'h00;
`endif
                        an   = 4'b0001 << k;
                        cand = {~an, m_dpm[k], seg};
                    end
                end
                if (MemWrite) begin
                    if (Address == VAL_A) begin
                        m_val = Write_data[15:0];
                    end else if (Address == CTRL_A) begin
                        m_dpm = Write_data[7:4];
                        if (!Write_data[0]) begin
                            cand = 12'hF00;
                        end else if (!m_en) begin
                            c0 = cyc;
                            snap.delete();
                            snap[0] = m_val;
                        end
                        m_en = Write_data[0];
                    end
                end
                if (m_en && (cyc - c0) > 0 && ((cyc - c0) % 16) == 0) begin
                    snap[(cyc - c0) / 16] = m_val;
                end
                if (cand != m_leds) begin
                    e.t = cyc;
                    e.v = cand;
                    q.push_back(e);
                    m_leds = cand;
                end
            end
        end
    end

    // Monitor: every change on leds must match the next predicted change.
    initial begin
        logic [11:0] prev;
        exp_t        e;
        prev = 12'hF00;
        forever begin
            @(negedge clk);
            if (leds !== prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL leds_seq: got %h at cycle %0d, wanted no change", leds, cyc);
                end else begin
                    e = q.pop_front();
                    if (leds !== e.v || (e.t >= 0 && e.t != cyc)) begin
                        bad++;
                        $display("FAIL leds_seq: got %h at cycle %0d, wanted %h at cycle %0d",
                                 leds, cyc, e.v, e.t);
                    end
                end
                prev = leds;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite   = 1'b1;
        Address    = a;
        Write_data = d;
        @(negedge clk);
        MemWrite   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input string name);
        logic [31:0] exp;
        exp = 32'h0;
        if (a == VAL_A)  exp = {16'h0, m_val};
        if (a == CTRL_A) exp = {24'h0, m_dpm, 3'b000, m_en};
        Address = a;
        MemRead = 1'b1;
        #1;
        check(name, Read_data, exp);
        MemRead = 1'b0;
    endtask

    task automatic wait_anode(input logic [3:0] an, input string name);
        int n;
        n = 0;
        while (leds[11:8] !== an && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL %s: anodes %h, wanted %h within 200 cycles", name, leds[11:8], an);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] v;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("reset_leds", {20'h0, leds}, 32'h0000_0F00);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_leds", {20'h0, leds}, 32'h0000_0F00);
        rd(VAL_A,  "idle_rd_val");
        rd(CTRL_A, "idle_rd_ctrl");

        // Basic scan of 0x12AF
        wr(VAL_A,  32'h0000_12AF);
        wr(CTRL_A, 32'h0000_0001);
        rd(VAL_A,  "rd_val_12af");
        rd(CTRL_A, "rd_ctrl_en");
        repeat (40) @(negedge clk);

        // Overwrite mid-frame: the current frame keeps the old value
        wait_anode(4'hD, "wait_digit1");
        wr(VAL_A, 32'h0000_0000);
        repeat (40) @(negedge clk);

        // Decimal points with a single-digit value
        wr(VAL_A,  32'h0000_0008);
        wr(CTRL_A, 32'h0000_0051);
        rd(CTRL_A, "rd_ctrl_51");
        repeat (40) @(negedge clk);

        // Disable during scan, then re-enable
        wr(CTRL_A, 32'h0000_0000);
        check("disable_leds", {20'h0, leds}, 32'h0000_0F00);
        wr(CTRL_A, 32'h0000_0001);
        repeat (30) @(negedge clk);

        // Randomized register traffic
        for (int i = 0; i < 10; i++) begin
            v = 16'($urandom) >> (4 * $urandom_range(0, 3));
            wr(VAL_A, {16'($urandom), v});
            d    = $urandom;
            d[0] = ($urandom_range(0, 3) != 0);
            wr(CTRL_A, d);
            if ($urandom_range(0, 2) == 0) wr(32'h4000_001C, $urandom);
            rd(VAL_A,  "rand_rd_val");
            rd(CTRL_A, "rand_rd_ctrl");
            repeat ($urandom_range(3, 40)) @(negedge clk);
        end

        // Reset in the middle of digit 2
        wr(CTRL_A, 32'h0000_0000);
        wr(VAL_A,  32'h0000_9C3E);
        wr(CTRL_A, 32'h0000_0001);
        wait_anode(4'hB, "wait_digit2");
        @(posedge clk);
        #2;
        if (m_leds != 12'hF00) begin
            exp_t e;
            e.t = -1;
            e.v = 12'hF00;
            q.push_back(e);
        end
        m_leds = 12'hF00;
        m_val  = 16'h0;
        m_dpm  = 4'h0;
        m_en   = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_reset_leds", {20'h0, leds}, 32'h0000_0F00);
        rd(VAL_A, "reset_rd_val");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("post_reset_leds", {20'h0, leds}, 32'h0000_0F00);
        rd(CTRL_A, "post_reset_rd_ctrl");

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending changes, wanted 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
